// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the iterative signed multiplier.
package mult_seq_pkg;

  // Default operand width.
  localparam int unsigned DefaultWidth = 8;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } mult_state_t;

  // Largest signed value a width-bit fractional result may take.
  function automatic longint frac_max(int unsigned width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  // Smallest signed value a width-bit fractional result may take.
  function automatic longint frac_min(int unsigned width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Loadable down-counter with zero flag; counts the RUN iterations.
module mult_iter_counter #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            load,
  input  logic            dec,
  input  logic [CntW-1:0] load_val,
  output logic [CntW-1:0] count,
  output logic            zero
);

  logic [CntW-1:0] count_q, count_d;

  // Load has priority over decrement.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/mult_seq.sv
// Iterative signed shift-add multiplier: full product plus saturated Q1.(WIDTH-1) result.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               wr_en,
  output logic [2*WIDTH-1:0] result_full,
  output logic [WIDTH-1:0]   result_frac
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  // Saturation bounds, widened to the product width for signed comparison.
  localparam logic signed [PW-1:0] SatHi = PW'(frac_max(WIDTH));
  localparam logic signed [PW-1:0] SatLo = PW'(frac_min(WIDTH));

  mult_state_t state_q, state_d;

  logic [WIDTH-1:0] mcand_q;   // |a|
  logic [PW-1:0]    acc_q;     // {partial product, remaining multiplier bits}
  logic             neg_q;     // sign of the final product
  logic [PW-1:0]    full_q;
  logic [WIDTH-1:0] frac_q;

  logic             accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    acc_step;
  logic signed [PW-1:0] prod_s;
  logic signed [PW-1:0] shifted;
  logic [WIDTH-1:0] frac_sat;

  logic [CntW-1:0]  cnt;
  logic             cnt_zero;
  logic             cnt_dec;
  logic             last_iter;

  // A new operation is only taken when no multiply is in flight.
  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  // |-2^(W-1)| wraps to 2^(W-1), which is still correct as an unsigned magnitude.
  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

  // One shift-add step: conditionally add |a| into the upper half, then shift right.
  always_comb begin
    sum      = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {sum, acc_q[WIDTH-1:1]};
  end

  // Sign fix-up, fractional alignment and saturation.
  always_comb begin
    prod_s  = neg_q ? -acc_q : acc_q;
    shifted = prod_s >>> (WIDTH - 1);
    if (shifted > SatHi) begin
      frac_sat = SatHi[WIDTH-1:0];
    end else if (shifted < SatLo) begin
      frac_sat = SatLo[WIDTH-1:0];
    end else begin
      frac_sat = shifted[WIDTH-1:0];
    end
  end

  assign cnt_dec   = (state_q == StRun) && !cnt_zero;
  assign last_iter = (cnt == CntW'(1));

  mult_iter_counter #(
    .CntW (CntW)
  ) u_iter_counter (
    .clk      (clk),
    .n_reset  (n_reset),
    .load     (accept),
    .dec      (cnt_dec),
    .load_val (CntW'(WIDTH)),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        // The counter hits zero with this cycle's step, so this is the last add.
        if (last_iter) state_d = StFix;
      end
      StFix: begin
        state_d = StDone;
      end
      StDone: begin
        state_d = start ? StRun : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register; reset aborts any in-flight multiply.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: operand latch, iteration, and result capture in FIX.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      full_q  <= '0;
      frac_q  <= '0;
    end else begin
      if (accept) begin
        mcand_q <= a_mag;
        acc_q   <= {{WIDTH{1'b0}}, b_mag};
        neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
      end else if (state_q == StRun) begin
        acc_q <= acc_step;
      end
      // Results hold until the next FIX, even across a new start.
      if (state_q == StFix) begin
        full_q <= prod_s;
        frac_q <= frac_sat;
      end
    end
  end

  assign busy        = (state_q == StRun) || (state_q == StFix);
  assign done        = (state_q == StDone);
  assign wr_en       = done;
  assign result_full = full_q;
  assign result_frac = frac_q;

endmodule

// File: doc/mult_seq.md
# mult_seq

Iterative signed shift-add multiplier for the picoMIPS datapath. Sits directly upstream of the write-back register: it accepts two WIDTH-bit two's-complement operands on a start pulse, computes the full 2·WIDTH-bit product over WIDTH cycles, and presents both the full product and a saturated Q1.(WIDTH-1) fractional result together with a one-cycle write-enable for the destination register.

## Interface
- WIDTH, 8, operand width in bits; must be ≥ 2.
- clk  in  1  system clock; all state updates on rising edge.
- n_reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  request a multiply; sampled only in IDLE or DONE.
- a  in  WIDTH  multiplicand, signed; sampled with start.
- b  in  WIDTH  multiplier, signed; sampled with start.
- busy  out  1  high in RUN and FIX.
- done  out  1  high for exactly one cycle when results become valid.
- wr_en  out  1  identical to done; drives the write-back register enable.
- result_full  out  2·WIDTH  signed product a·b.
- result_frac  out  WIDTH  product >>> (WIDTH-1), saturated to signed WIDTH range.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: start=1 → latch |a|, |b| as WIDTH-bit unsigned (|-2^(W-1)| = 2^(W-1) fits), latch sign = a[W-1]^b[W-1], clear accumulator, load iteration counter with WIDTH → RUN. start=0 → stay.
- RUN: each cycle, if multiplier LSB=1, add multiplicand to accumulator upper half; shift accumulator/multiplier right by one; decrement counter. Counter reaching 0 after the add → FIX.
- FIX: negate magnitude product if sign=1; compute arithmetic shift right by WIDTH-1; saturate to [-2^(W-1), 2^(W-1)-1]; register result_full and result_frac → DONE.
- DONE: done=wr_en=1 for this one cycle. start=1 → accepted exactly as in IDLE (→ RUN); otherwise → IDLE.
- Results hold their value from FIX until the next FIX; they are not cleared by the next start.
- start while busy=1 is ignored; no queuing.
- Only -2^(W-1)·-2^(W-1) overflows the fractional range; result_frac = 2^(W-1)-1 (0x7F at W=8). result_full never overflows.
- Product of zero with sign=1 yields 0 (no negative zero issue in two's complement).

## Timing
- Reset (n_reset=0 at an edge): state=IDLE, busy=0, done=0, wr_en=0, result_full=0, result_frac=0, counter=0. Reset wins over start and over any in-flight operation; an aborted multiply produces no done.
- Latency: start sampled at edge 0 → iterations at edges 1..WIDTH → FIX at edge WIDTH+1 → done high during the cycle following edge WIDTH+1 (W=8: 9 cycles start-to-done).
- busy rises in the cycle after the start edge and falls in the same cycle done rises.
- Back-to-back: start held high in DONE gives a throughput of one result per WIDTH+2 cycles.
- a/b are don't-care except at the sampling edge.

## Structure
- Shared package (constants.sv): mult_state_t enum {IDLE, RUN, FIX, DONE}; default WIDTH constant; saturation limits as functions of WIDTH.
- One natural sub-module: mult_iter_counter, a loadable down-counter of clog2(WIDTH+1) bits with zero flag, used for the RUN iteration count.
- Datapath (accumulator, shift, negate, saturate) stays in mult_seq.

## Test plan
- a=3, b=5 → after 9 cycles done=1 one cycle, result_full=0x000F, result_frac=0x00, wr_en=done.
- a=0x40, b=0x40 (0.5·0.5) → result_full=0x1000, result_frac=0x20; a=0xC0, b=0x40 → result_full=0xF000, result_frac=0xE0.
- a=0x80, b=0x80 → result_full=0x4000, result_frac saturated to 0x7F; a=0x80, b=0x7F → result_full=0xC080, result_frac=0x81.
- start pulsed again at cycles 2 and 5 of a running multiply with different operands → ignored; done once at cycle 9 with first operands only.
- n_reset=0 at cycle 4 of a multiply → next cycle all outputs 0, state IDLE, no done ever emitted for that operation; fresh start afterwards completes in 9 cycles.
- start held high continuously with changing operands → done pulses every 10 cycles, each result matches operands sampled at the corresponding accepting edge.
